// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: format encodings and
// occupancy states of the output/skid register pair.
package imm_pkg;

   localparam int IMM_SRC_W = 4;

   typedef enum logic [IMM_SRC_W-1:0] {
      IMM_I  = 4'b0000,
      IMM_S  = 4'b0001,
      IMM_B  = 4'b0010,
      IMM_J  = 4'b0011,
      IMM_U  = 4'b0100,
      IMM_SH = 4'b0101,
      IMM_Z  = 4'b0110,
      IMM_CI = 4'b1000,
      IMM_CJ = 4'b1001,
      IMM_CB = 4'b1010
   } imm_src_e;

   // Encoding mirrors {skid_valid, out_valid}; 2'b10 can never occur.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_ONE   = 2'b01,
      OCC_FULL  = 2'b11
   } occ_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus of the immediate-generation stage: instruction side in,
// extended-immediate side out. The stage itself takes the slave view.
interface imm_gen_stage_if
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          instr;
   logic [IMM_SRC_W-1:0] imm_src;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      imm_ext;
   logic [TAG_W-1:0]     out_tag;
   logic                 illegal;

   modport master (
      output in_valid, instr, imm_src, in_tag, out_ready,
      input  in_ready, out_valid, imm_ext, out_tag, illegal
   );

   modport slave (
      input  in_valid, instr, imm_src, in_tag, out_ready,
      output in_ready, out_valid, imm_ext, out_tag, illegal
   );

endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign/zero extension to XLEN.
// RVC formats CI/CJ/CB are decoded only when COMPRESSED_IMM_EN is defined.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]          instr,
   input  logic [IMM_SRC_W-1:0] imm_src,
   output logic [XLEN-1:0]      imm,
   output logic                 illegal
);

   logic [31:0] val;
   logic        sext;
   logic        unused_low_bits;

   // Opcode and quadrant bits carry no immediate in the 32-bit formats.
   assign unused_low_bits = ^instr[6:0];

   // NOTE: every output of a combinational block gets a default before the
   // case, otherwise an unassigned path infers a latch.
   always_comb begin
      val     = '0;
      sext    = 1'b0;
      illegal = 1'b0;
      case (imm_src_e'(imm_src))
         IMM_I:  begin val = 32'($signed(instr[31:20])); sext = 1'b1; end
         IMM_S:  begin val = 32'($signed({instr[31:25], instr[11:7]})); sext = 1'b1; end
         IMM_B:  begin
            val  = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            sext = 1'b1;
         end
         IMM_J:  begin
            val  = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            sext = 1'b1;
         end
         IMM_U:  begin val = {instr[31:12], 12'b0}; sext = 1'b1; end
         IMM_SH: begin
            if (XLEN == 64) val = 32'(instr[25:20]);
            else            val = 32'(instr[24:20]);
         end
         IMM_Z:  val = 32'(instr[19:15]);
`ifdef COMPRESSED_IMM_EN
         IMM_CI: begin val = 32'($signed({instr[12], instr[6:2]})); sext = 1'b1; end
         IMM_CJ: begin
            val  = 32'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                instr[2], instr[11], instr[5:3], 1'b0}));
            sext = 1'b1;
         end
         IMM_CB: begin
            val  = 32'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                instr[4:3], 1'b0}));
            sext = 1'b1;
         end
`endif
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      if (sext) imm = XLEN'($signed(val));
      else      imm = XLEN'(val);
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer so that
// in_ready is a flop. Optional RVC formats: define COMPRESSED_IMM_EN.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input logic            clk,
   input logic            rst,
   input logic            flush,
   imm_gen_stage_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   entry_t in_entry, out_q, skid_q;
   occ_e   state_q, state_d;
   logic   in_ready_q;
   logic   accept, drain, load_out, load_skid, out_from_skid;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (bus.instr),
      .imm_src (bus.imm_src),
      .imm     (in_entry.imm),
      .illegal (in_entry.illegal)
   );
   assign in_entry.tag = bus.in_tag;

   assign accept = bus.in_valid && in_ready_q && !flush;
   assign drain  = (state_q != OCC_EMPTY) && bus.out_ready;

   always_comb begin
      state_d       = state_q;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      case (state_q)
         OCC_EMPTY: if (accept) begin state_d = OCC_ONE; load_out = 1'b1; end
         OCC_ONE: begin
            if (drain && accept)  load_out = 1'b1;
            else if (drain)       state_d = OCC_EMPTY;
            else if (accept)      begin state_d = OCC_FULL; load_skid = 1'b1; end
         end
         OCC_FULL: if (drain) begin
            state_d       = OCC_ONE;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
         end
         default: state_d = OCC_EMPTY;
      endcase
      if (flush) state_d = OCC_EMPTY;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != OCC_FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)           out_q <= '0;
      else if (load_out) out_q <= out_from_skid ? skid_q : in_entry;
   end

   // NOTE: skid payload is qualified by the state register, so it needs no
   // reset; only the visible output fields are cleared.
   always_ff @(posedge clk) begin
      if (load_skid) skid_q <= in_entry;
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != OCC_EMPTY);
   assign bus.imm_ext   = out_q.imm;
   assign bus.out_tag   = out_q.tag;
   assign bus.illegal   = out_q.illegal;

endmodule
